// File: rtl/calc_display_pkg.sv
// Shared display types for the calculator's 7-segment driver and its capture monitor.
// Segment constants are active-low, bit order {g,f,e,d,c,b,a}.
package calc_display_pkg;

  typedef logic [3:0] bcd_t;

  localparam int NUM_DIGITS = 4;

  typedef bcd_t [NUM_DIGITS-1:0] frame_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    COLLECT,
    CONVERT
  } cap_state_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational active-low segment pattern to BCD decoder.
// A blank digit reads as 0; anything that is not 0-9 or blank clears o_valid.
module seg_decode
  import calc_display_pkg::*;
(
  input  logic [6:0] i_seg,
  output bcd_t       o_digit,
  output logic       o_valid
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_digit = '0;
    o_valid = 1'b1;
    case (i_seg)
      SEG_0, SEG_BLANK: o_digit = 4'd0;
      SEG_1:            o_digit = 4'd1;
      SEG_2:            o_digit = 4'd2;
      SEG_3:            o_digit = 4'd3;
      SEG_4:            o_digit = 4'd4;
      SEG_5:            o_digit = 4'd5;
      SEG_6:            o_digit = 4'd6;
      SEG_7:            o_digit = 4'd7;
      SEG_8:            o_digit = 4'd8;
      SEG_9:            o_digit = 4'd9;
      default:          o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Receive-side monitor for the multiplexed 7-segment display: samples settled digits,
// requires STABLE_SCANS identical frames, then converts the BCD frame to binary.
module display_capture
  import calc_display_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_SCANS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIGITS-1:0] digit_select,
  input  logic [6:0]            led_select,
  output logic [13:0]           number,
  output logic                  number_valid,
  output logic                  decode_error
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int MW = $clog2(STABLE_SCANS + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SETTLE_CYCLES - 2);
  localparam logic [CW-1:0] SETTLED   = CW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_SCANS);

  logic [NUM_DIGITS-1:0] r_dig, r_dig_q;
  logic [6:0]            r_seg, r_seg_q;
  logic [CW-1:0]         r_settle;
  frame_t                r_slots, r_prev, r_snap;
  logic [NUM_DIGITS-1:0] r_seen;
  logic [MW-1:0]         r_match;
  cap_state_t            r_state;
  logic [IW-1:0]         r_idx;
  logic [13:0]           r_acc;
  logic                  r_load;

  logic          w_change, w_one_hot, w_sample, w_seg_ok;
  logic          w_complete, w_same, w_trigger;
  bcd_t          w_digit;
  logic [IW-1:0] w_idx;
  logic [MW-1:0] w_match_next;

  seg_decode u_seg_decode (
    .i_seg   (r_seg),
    .o_digit (w_digit),
    .o_valid (w_seg_ok)
  );

  assign w_change  = (r_dig != r_dig_q) || (r_seg != r_seg_q);
  assign w_one_hot = ($countones(~r_dig) == 1);
  assign w_sample  = !w_change && w_one_hot && (r_settle == SAMPLE_AT);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!r_dig[i]) w_idx = IW'(i);
    end
  end

  assign w_complete   = (r_seen == '1);
  assign w_same       = (r_slots == r_prev);
  assign w_match_next = w_same ? ((r_match == MATCH_MAX) ? r_match : r_match + 1'b1)
                               : MW'(1);
  // A differing frame re-triggers when one scan is enough to count as stable.
  assign w_trigger    = w_complete && (w_match_next == MATCH_MAX) &&
                        ((r_match != MATCH_MAX) || !w_same);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dig        <= '1;
      r_dig_q      <= '1;
      r_seg        <= '1;
      r_seg_q      <= '1;
      r_settle     <= '0;
      r_slots      <= '0;
      r_prev       <= '0;
      r_seen       <= '0;
      r_match      <= '0;
      decode_error <= 1'b0;
    end else begin
      r_dig        <= digit_select;
      r_dig_q      <= r_dig;
      r_seg        <= led_select;
      r_seg_q      <= r_seg;
      decode_error <= 1'b0;

      if (w_change)                             r_settle <= '0;
      else if (w_one_hot && r_settle != SETTLED) r_settle <= r_settle + 1'b1;

      if (w_complete) begin
        r_match <= w_match_next;
        r_prev  <= r_slots;
        r_seen  <= '0;
      end

      // NOTE: the last non-blocking assignment to a register in a block wins.
      if (w_sample) begin
        if (w_seg_ok) begin
          r_slots[w_idx] <= w_digit;
          r_seen[w_idx]  <= 1'b1;
        end else begin
          decode_error <= 1'b1;
          r_seen       <= '0;
          r_match      <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= COLLECT;
      r_snap       <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_load       <= 1'b0;
      number       <= '0;
      number_valid <= 1'b0;
    end else begin
      number_valid <= 1'b0;
      r_load       <= 1'b0;
      if (r_load) begin
        number       <= r_acc;
        number_valid <= 1'b1;
      end
      case (r_state)
        COLLECT: begin
          if (w_trigger) begin
            r_snap  <= r_slots;
            r_acc   <= '0;
            r_idx   <= IW'(NUM_DIGITS - 1);
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          // Most significant digit first: acc = acc*10 + d.
          r_acc <= (r_acc << 3) + (r_acc << 1) + 14'(r_snap[r_idx]);
          r_idx <= r_idx - 1'b1;
          if (r_idx == '0) begin
            r_state <= COLLECT;
            r_load  <= 1'b1;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule
